// File: rtl/bus_region_ctrl.sv
`timescale 1ns/1ps
// bus_region_ctrl: bridges a CPU bus onto two word-addressed RAM regions
// (stack at byte 0, program at PROG_BASE). Each access runs
// IDLE -> WAIT x WAIT_CYCLES -> ACCESS -> DONE, issuing one RAM strobe.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   cpu_address/read/write/byteenable/writedata   CPU request
//   cpu_waitrequest       low for exactly the completing (DONE) cycle
//   cpu_readdata          read data, 0 outside DONE
//   ram_address/byteenable/writedata   latched request towards the RAMs
//   stack_read/write, prog_read/write  single-cycle RAM strobes
//   stack_readdata/prog_readdata       RAM data, valid the cycle after a read strobe
//   bus_error             sticky: unmapped access or read+write together
//   txn_count             completed transfers, wraps at 16 bits
module bus_region_ctrl #(
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter logic [31:0] PROG_BASE    = 32'hBFC0_0000,
   parameter int unsigned REGION_BYTES = 16384
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_address,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [3:0]  cpu_byteenable,
   input  logic [31:0] cpu_writedata,
   output logic        cpu_waitrequest,
   output logic [31:0] cpu_readdata,
   output logic [11:0] ram_address,
   output logic [3:0]  ram_byteenable,
   output logic [31:0] ram_writedata,
   output logic        stack_read,
   output logic        stack_write,
   output logic        prog_read,
   output logic        prog_write,
   input  logic [31:0] stack_readdata,
   input  logic [31:0] prog_readdata,
   output logic        bus_error,
   output logic [15:0] txn_count
);

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam int unsigned WORD_W = 12;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned TXN_W  = 16;
   localparam int unsigned STB_W  = 4;

   localparam logic [AW-1:0]    REGION_SIZE = AW'(REGION_BYTES);
   localparam logic [CNT_W-1:0] WAIT_INIT   = CNT_W'(WAIT_CYCLES);

   // Strobe vector bit positions
   localparam int unsigned STB_SR = 0;
   localparam int unsigned STB_SW = 1;
   localparam int unsigned STB_PR = 2;
   localparam int unsigned STB_PW = 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      R_NONE  = 2'd0,
      R_STACK = 2'd1,
      R_PROG  = 2'd2
   } region_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_next_cnt;
   logic               w_latch;
   logic [STB_W-1:0]   w_next_strobe;

   region_t            r_region;
   region_t            w_region;
   region_t            w_acc_region;
   logic               r_is_write;
   logic               w_acc_write;

   logic [WORD_W-1:0]  r_ram_address;
   logic [BE_W-1:0]    r_ram_byteenable;
   logic [DW-1:0]      r_ram_writedata;
   logic [STB_W-1:0]   r_strobe;
   logic               r_waitrequest;
   logic               r_bus_error;
   logic [TXN_W-1:0]   r_txn_count;
   logic [DW-1:0]      w_readdata;

   logic               w_in_stack;
   logic               w_in_prog;
   logic [AW-1:0]      w_prog_off;

   // Address decode; the offset form avoids overflow of PROG_BASE+REGION_BYTES
   assign w_prog_off = cpu_address - PROG_BASE;
   assign w_in_stack = (cpu_address < REGION_SIZE);
   assign w_in_prog  = (cpu_address >= PROG_BASE) && (w_prog_off < REGION_SIZE);

   // Region captured at request time; read+write together is treated as unmapped
   always_comb begin
      w_region = R_NONE;
      if (cpu_read && cpu_write) begin
         w_region = R_NONE;
      end else if (w_in_stack) begin
         w_region = R_STACK;
      end else if (w_in_prog) begin
         w_region = R_PROG;
      end
   end

   // With zero wait states ACCESS is entered on the latching edge, so the
   // strobe must be chosen from the live request rather than the latches
   assign w_acc_region = w_latch ? w_region  : r_region;
   assign w_acc_write  = w_latch ? cpu_write : r_is_write;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_next_state  = r_state;
      w_next_cnt    = r_cnt;
      w_latch       = 1'b0;
      w_next_strobe = '0;

      case (r_state)
         S_IDLE: begin
            if (cpu_read || cpu_write) begin
               w_latch = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_next_state = S_ACCESS;
               end else begin
                  w_next_state = S_WAIT;
                  w_next_cnt   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            w_next_cnt = r_cnt - CNT_W'(1);
            if (r_cnt <= CNT_W'(1)) begin
               w_next_state = S_ACCESS;
            end
         end
         S_ACCESS: begin
            w_next_state = S_DONE;
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
         end
      endcase

      if (w_next_state == S_ACCESS) begin
         case (w_acc_region)
            R_STACK: begin
               if (w_acc_write) w_next_strobe[STB_SW] = 1'b1;
               else             w_next_strobe[STB_SR] = 1'b1;
            end
            R_PROG: begin
               if (w_acc_write) w_next_strobe[STB_PW] = 1'b1;
               else             w_next_strobe[STB_PR] = 1'b1;
            end
            default: w_next_strobe = '0;
         endcase
      end
   end

   // Registered outputs, request latches and status
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_waitrequest    <= 1'b1;
         r_strobe         <= '0;
         r_ram_address    <= '0;
         r_ram_byteenable <= '0;
         r_ram_writedata  <= '0;
         r_is_write       <= 1'b0;
         r_region         <= R_NONE;
         r_bus_error      <= 1'b0;
         r_txn_count      <= '0;
      end else begin
         r_waitrequest <= (w_next_state != S_DONE);
         r_strobe      <= w_next_strobe;
         if (w_latch) begin
            r_ram_address    <= cpu_address[WORD_W+1:2];
            r_ram_byteenable <= cpu_byteenable;
            r_ram_writedata  <= cpu_writedata;
            r_is_write       <= cpu_write;
            r_region         <= w_region;
         end
         // Status updates on DONE entry so they are visible while the CPU completes
         if (w_next_state == S_DONE) begin
            r_txn_count <= r_txn_count + TXN_W'(1);
            if (r_region == R_NONE) begin
               r_bus_error <= 1'b1;
            end
         end
      end
   end

   // Read data is passed straight from the RAM: it only becomes valid in DONE
   always_comb begin
      w_readdata = '0;
      if ((r_state == S_DONE) && !r_is_write) begin
         case (r_region)
            R_STACK: w_readdata = stack_readdata;
            R_PROG:  w_readdata = prog_readdata;
            default: w_readdata = '0;
         endcase
      end
   end

   assign cpu_waitrequest = r_waitrequest;
   assign cpu_readdata    = w_readdata;
   assign ram_address     = r_ram_address;
   assign ram_byteenable  = r_ram_byteenable;
   assign ram_writedata   = r_ram_writedata;
   assign stack_read      = r_strobe[STB_SR];
   assign stack_write     = r_strobe[STB_SW];
   assign prog_read       = r_strobe[STB_PR];
   assign prog_write      = r_strobe[STB_PW];
   assign bus_error       = r_bus_error;
   assign txn_count       = r_txn_count;

endmodule

// File: tb/tb_bus_region_ctrl.sv
`timescale 1ns/1ps
// Testbench for bus_region_ctrl: randomized CPU traffic against a transaction-level
// reference model, with expectations queued at issue time and checked by a monitor.
module tb_bus_region_ctrl;

   localparam int unsigned W      = 2;
   localparam logic [31:0] PBASE  = 32'hBFC0_0000;
   localparam int unsigned RBYTES = 16384;
   localparam int unsigned NWORDS = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_address;
   logic        cpu_read, cpu_write;
   logic [3:0]  cpu_byteenable;
   logic [31:0] cpu_writedata;
   logic        cpu_waitrequest;
   logic [31:0] cpu_readdata;
   logic [11:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic [31:0] ram_writedata;
   logic        stack_read, stack_write, prog_read, prog_write;
   logic [31:0] stack_rd, prog_rd;
   logic        bus_error;
   logic [15:0] txn_count;

   // Second instance with zero wait states for back-to-back timing
   logic [31:0] c0_address;
   logic        c0_read, c0_write;
   logic [3:0]  c0_be;
   logic [31:0] c0_wdata;
   logic [31:0] c0_stack_rd, c0_prog_rd;
   logic        c0_wait;
   logic [31:0] c0_rdata;
   logic [11:0] c0_ram_address;
   logic [3:0]  c0_ram_be;
   logic [31:0] c0_ram_wdata;
   logic        c0_sr, c0_sw, c0_pr, c0_pw;
   logic        c0_err;
   logic [15:0] c0_count;

   always #5 clk = ~clk;

   bus_region_ctrl #(.WAIT_CYCLES(W), .PROG_BASE(PBASE), .REGION_BYTES(RBYTES)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_byteenable(cpu_byteenable), .cpu_writedata(cpu_writedata),
      .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
      .stack_read(stack_read), .stack_write(stack_write),
      .prog_read(prog_read), .prog_write(prog_write),
      .stack_readdata(stack_rd), .prog_readdata(prog_rd),
      .bus_error(bus_error), .txn_count(txn_count)
   );

   bus_region_ctrl #(.WAIT_CYCLES(0), .PROG_BASE(PBASE), .REGION_BYTES(RBYTES)) u_dut0 (
      .clk(clk), .reset(reset),
      .cpu_address(c0_address), .cpu_read(c0_read), .cpu_write(c0_write),
      .cpu_byteenable(c0_be), .cpu_writedata(c0_wdata),
      .cpu_waitrequest(c0_wait), .cpu_readdata(c0_rdata),
      .ram_address(c0_ram_address), .ram_byteenable(c0_ram_be), .ram_writedata(c0_ram_wdata),
      .stack_read(c0_sr), .stack_write(c0_sw),
      .prog_read(c0_pr), .prog_write(c0_pw),
      .stack_readdata(c0_stack_rd), .prog_readdata(c0_prog_rd),
      .bus_error(c0_err), .txn_count(c0_count)
   );

   int          checks = 0;
   int          fails  = 0;
   int unsigned cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM models attached to the DUT
   logic [31:0] stack_mem [NWORDS];
   logic [31:0] prog_mem  [NWORDS];

   always @(posedge clk) begin
      if (stack_read) stack_rd <= stack_mem[ram_address];
      if (prog_read)  prog_rd  <= prog_mem[ram_address];
      for (int b = 0; b < 4; b++) begin
         if (stack_write && ram_byteenable[b]) stack_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         if (prog_write  && ram_byteenable[b]) prog_mem[ram_address][8*b +: 8]  <= ram_writedata[8*b +: 8];
      end
   end

   // Reference model state
   logic [31:0] ref_stack [NWORDS];
   logic [31:0] ref_prog  [NWORDS];
   logic        m_err;
   logic [15:0] m_count;

   typedef struct {
      bit          mapped;
      bit          is_write;
      bit          is_prog;
      logic [11:0] word;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic [15:0] count;
      int unsigned issue_cyc;
   } exp_t;

   exp_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic int expcode(input exp_t e);
      if (!e.mapped) return 0;
      return e.is_prog ? (e.is_write ? 4 : 3) : (e.is_write ? 2 : 1);
   endfunction

   // Apply a request and record what the bus should do with it
   task automatic issue(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [3:0] be, input logic [31:0] wd);
      exp_t    e;
      longint  la;
      bit      in_s, in_p;
      la   = longint'(a);
      in_s = la < longint'(RBYTES);
      in_p = (la >= longint'(PBASE)) && (la < longint'(PBASE) + longint'(RBYTES));
      e.mapped   = !(rd && wr) && (in_s || in_p);
      e.is_write = wr;
      e.is_prog  = in_p;
      e.word     = a[13:2];
      e.be       = be;
      e.wdata    = wd;
      e.rdata    = 32'h0;
      if (e.mapped) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) begin
                  if (in_p) ref_prog[e.word][8*b +: 8]  = wd[8*b +: 8];
                  else      ref_stack[e.word][8*b +: 8] = wd[8*b +: 8];
               end
         end else begin
            e.rdata = in_p ? ref_prog[e.word] : ref_stack[e.word];
         end
      end
      m_err      = m_err | !e.mapped;
      m_count    = m_count + 16'd1;
      e.err      = m_err;
      e.count    = m_count;
      e.issue_cyc = cyc;
      sb_q.push_back(e);
      cpu_address    = a;
      cpu_read       = rd;
      cpu_write      = wr;
      cpu_byteenable = be;
      cpu_writedata  = wd;
   endtask

   // One transfer; called just after a rising edge with the DUT idle
   task automatic run_txn(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [31:0] wd, input bit scramble);
      bit done = 0;
      issue(a, rd, wr, be, wd);
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (!cpu_waitrequest) begin
            done = 1;
            break;
         end
         @(posedge clk);
         #1;
         if (scramble) begin
            cpu_address    = $urandom;
            cpu_read       = 1'($urandom);
            cpu_write      = 1'($urandom);
            cpu_byteenable = 4'($urandom);
            cpu_writedata  = $urandom;
         end
      end
      if (!done) begin
         checks++;
         fails++;
         $display("FAIL txn_timeout: got no completion expected completion for address %h", a);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      @(posedge clk);
      #1;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cpu_address = $urandom;
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: strobes and completions are matched against queued expectations
   int          mon_n;
   int          mon_code;
   int unsigned seen = 0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (!reset) begin
         seen = 0;
      end else begin
         mon_n = int'(stack_read) + int'(stack_write) + int'(prog_read) + int'(prog_write);
         if (mon_n != 0) begin
            if (sb_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL stray_strobe: got strobe at word %h expected none", ram_address);
            end else begin
               mon_code = stack_read ? 1 : stack_write ? 2 : prog_read ? 3 : 4;
               chk("strobes_per_cycle", 32'(mon_n), 32'd1);
               chk("strobe_kind", 32'(mon_code), 32'(expcode(sb_q[0])));
               chk("strobe_ram_address", 32'(ram_address), 32'(sb_q[0].word));
               chk("strobe_byteenable", 32'(ram_byteenable), 32'(sb_q[0].be));
               if (sb_q[0].is_write) chk("strobe_writedata", ram_writedata, sb_q[0].wdata);
               chk("strobe_cycle", cyc - sb_q[0].issue_cyc, 32'(W + 1));
               seen++;
            end
         end
         if (!cpu_waitrequest) begin
            if (sb_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL stray_done: got completion expected none");
            end else begin
               mon_e = sb_q.pop_front();
               chk("readdata", cpu_readdata, mon_e.rdata);
               chk("bus_error", 32'(bus_error), 32'(mon_e.err));
               chk("txn_count", 32'(txn_count), 32'(mon_e.count));
               chk("latency", cyc - mon_e.issue_cyc, 32'(W + 2));
               chk("strobes_per_txn", seen, mon_e.mapped ? 32'd1 : 32'd0);
               seen = 0;
            end
         end else begin
            chk("readdata_outside_done", cpu_readdata, 32'h0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] a;
      int          kind;
      int          bucket;
      int          dones;
      int          strobes;
      int unsigned last;

      reset = 1'b0;
      cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_byteenable = '0; cpu_writedata = '0;
      c0_address = 32'h0000_0100; c0_read = 0; c0_write = 0; c0_be = 4'hF; c0_wdata = '0;
      c0_stack_rd = 32'hCAFE_0001; c0_prog_rd = 32'h0;
      m_err = 0;
      m_count = '0;
      for (int i = 0; i < int'(NWORDS); i++) begin
         v = $urandom; stack_mem[i] = v; ref_stack[i] = v;
         v = $urandom; prog_mem[i]  = v; ref_prog[i]  = v;
      end
      stack_mem[4] = 32'h0; ref_stack[4] = 32'h0;
      prog_mem[1]  = 32'h2402_0005; ref_prog[1] = 32'h2402_0005;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_waitrequest", 32'(cpu_waitrequest), 32'd1);
      chk("rst_readdata", cpu_readdata, 32'h0);
      chk("rst_bus_error", 32'(bus_error), 32'd0);
      chk("rst_txn_count", 32'(txn_count), 32'd0);
      chk("rst_strobes", 32'({stack_read, stack_write, prog_read, prog_write}), 32'd0);
      chk("rst_ram_address", 32'(ram_address), 32'd0);
      chk("rst_ram_be", 32'(ram_byteenable), 32'd0);
      chk("rst_ram_wdata", ram_writedata, 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Directed transfers, including region boundaries
      run_txn(32'hBFC0_0004, 1, 0, 4'hF, 32'h0, 0);
      run_txn(32'h0000_0010, 0, 1, 4'b0011, 32'hDEAD_BEEF, 0);
      run_txn(32'h0000_0010, 1, 0, 4'hF, 32'h0, 0);
      run_txn(32'h8000_0000, 1, 0, 4'hF, 32'h0, 0);
      run_txn(32'h0000_0020, 1, 0, 4'hF, 32'h0, 0);
      run_txn(32'h0000_0040, 1, 1, 4'hF, 32'h1234_5678, 0);
      run_txn(32'h0000_3FFC, 1, 0, 4'hF, 32'h0, 0);
      run_txn(32'h0000_4000, 1, 0, 4'hF, 32'h0, 0);
      run_txn(32'hBFC0_3FFC, 0, 1, 4'b1100, 32'hA5A5_5A5A, 1);
      run_txn(32'hBFC0_3FFC, 1, 0, 4'hF, 32'h0, 0);
      run_txn(32'hBFC0_4000, 0, 1, 4'hF, 32'h0, 0);
      run_txn(32'hBFBF_FFFC, 1, 0, 4'hF, 32'h0, 0);

      // Reset in the middle of a WAIT phase discards the transfer
      issue(32'h0000_0100, 1, 0, 4'hF, 32'h0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("midrst_waitrequest", 32'(cpu_waitrequest), 32'd1);
      chk("midrst_readdata", cpu_readdata, 32'h0);
      chk("midrst_bus_error", 32'(bus_error), 32'd0);
      chk("midrst_txn_count", 32'(txn_count), 32'd0);
      chk("midrst_strobes", 32'({stack_read, stack_write, prog_read, prog_write}), 32'd0);
      chk("midrst_ram_address", 32'(ram_address), 32'd0);
      sb_q.delete();
      m_err = 0;
      m_count = '0;
      cpu_read = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      idle(3);
      run_txn(32'h0000_0010, 1, 0, 4'hF, 32'h0, 0);

      // Randomized traffic
      for (int t = 0; t < 300; t++) begin
         bucket = $urandom_range(0, 4);
         case (bucket)
            0, 1:    a = 32'($urandom_range(0, RBYTES - 1));
            2, 3:    a = PBASE + 32'($urandom_range(0, RBYTES - 1));
            default: a = $urandom;
         endcase
         kind = $urandom_range(0, 9);
         run_txn(a, kind == 0 || kind > 4, kind <= 4, 4'($urandom), $urandom, 1'($urandom));
         idle($urandom_range(0, 2));
      end

      // Counter wrap
      force u_dut.r_txn_count = 16'hFFFF;
      #1;
      release u_dut.r_txn_count;
      m_count = 16'hFFFF;
      @(posedge clk);
      #1;
      run_txn(32'h0000_0004, 1, 0, 4'hF, 32'h0, 0);
      run_txn(32'hBFC0_0008, 1, 0, 4'hF, 32'h0, 0);

      // Zero wait states with the request held: one completion every third cycle
      c0_read = 1'b1;
      dones   = 0;
      strobes = 0;
      last    = cyc;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (c0_sr) strobes++;
         chk("w0_other_strobes", 32'({c0_sw, c0_pr, c0_pw}), 32'd0);
         if (!c0_wait) begin
            chk("w0_done_spacing", cyc - last, dones == 0 ? 32'd2 : 32'd3);
            chk("w0_readdata", c0_rdata, 32'hCAFE_0001);
            last = cyc;
            dones++;
         end
      end
      chk("w0_done_count", 32'(dones), 32'd10);
      chk("w0_strobe_count", 32'(strobes), 32'd10);
      chk("w0_txn_count", 32'(c0_count), 32'd10);
      chk("w0_bus_error", 32'(c0_err), 32'd0);
      @(posedge clk);
      #1;
      c0_read = 1'b0;

      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
